// File: rtl/mdu_if.sv
// Handshake and data bundle between the E-stage pipeline register and the
// multiply/divide unit: request fields in, busy flag and HI/LO out.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, A, B, input busy, HI, LO);
    modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: computes the result at issue, holds it in a
// shadow pair and commits to HI/LO after a fixed multi-cycle busy window.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic [31:0] shi_r, shi_nxt_s, slo_r, slo_nxt_s;
    logic        dz_r, dz_nxt_s;
    logic [31:0] hi_r, hi_nxt_s, lo_r, lo_nxt_s;
    logic        busy_r, busy_nxt_s;

    logic [63:0] prod_signed_s, prod_unsigned_s;
    logic [31:0] divisor_s, abs_a_s, abs_b_s, mag_q_s, mag_r_s;
    logic [31:0] quot_s_s, rem_s_s, quot_u_s, rem_u_s;

    // Result datapath; signed division works on magnitudes so INT_MIN/-1 wraps cleanly
    always_comb begin
        prod_signed_s   = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_unsigned_s = {32'd0, bus.A} * {32'd0, bus.B};
        divisor_s       = (bus.B == 32'd0) ? 32'd1 : bus.B;
        abs_a_s         = bus.A[31] ? (32'd0 - bus.A) : bus.A;
        abs_b_s         = divisor_s[31] ? (32'd0 - divisor_s) : divisor_s;
        mag_q_s         = abs_a_s / abs_b_s;
        mag_r_s         = abs_a_s % abs_b_s;
        quot_s_s        = (bus.A[31] ^ divisor_s[31]) ? (32'd0 - mag_q_s) : mag_q_s;
        rem_s_s         = bus.A[31] ? (32'd0 - mag_r_s) : mag_r_s;
        quot_u_s        = bus.A / divisor_s;
        rem_u_s         = bus.A % divisor_s;
    end

    // Next-state and next-register values for the IDLE/RUN controller
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        shi_nxt_s   = shi_r;
        slo_nxt_s   = slo_r;
        dz_nxt_s    = dz_r;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT: begin
                            {shi_nxt_s, slo_nxt_s} = prod_signed_s;
                            dz_nxt_s    = 1'b0;
                            cnt_nxt_s   = MULT_CNT;
                            state_nxt_s = RUN;
                        end
                        OP_MULTU: begin
                            {shi_nxt_s, slo_nxt_s} = prod_unsigned_s;
                            dz_nxt_s    = 1'b0;
                            cnt_nxt_s   = MULT_CNT;
                            state_nxt_s = RUN;
                        end
                        OP_DIV: begin
                            shi_nxt_s   = rem_s_s;
                            slo_nxt_s   = quot_s_s;
                            dz_nxt_s    = (bus.B == 32'd0);
                            cnt_nxt_s   = DIV_CNT;
                            state_nxt_s = RUN;
                        end
                        OP_DIVU: begin
                            shi_nxt_s   = rem_u_s;
                            slo_nxt_s   = quot_u_s;
                            dz_nxt_s    = (bus.B == 32'd0);
                            cnt_nxt_s   = DIV_CNT;
                            state_nxt_s = RUN;
                        end
                        OP_MTHI: hi_nxt_s = bus.A;
                        OP_MTLO: lo_nxt_s = bus.A;
                        default: begin
                        end
                    endcase
                end else begin
                end
            end
            RUN: begin
                // Requests arriving while busy are dropped; only the countdown advances
                if (cnt_r == 4'd1) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = IDLE;
                    if (!dz_r) begin
                        hi_nxt_s = shi_r;
                        lo_nxt_s = slo_r;
                    end else begin
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        busy_nxt_s = (state_nxt_s == RUN);
    end

    // State, shadow and architectural registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            shi_r   <= 32'd0;
            slo_r   <= 32'd0;
            dz_r    <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shi_r   <= shi_nxt_s;
            slo_r   <= slo_nxt_s;
            dz_r    <= dz_nxt_s;
            hi_r    <= hi_nxt_s;
            lo_r    <= lo_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: driver pushes expected outcomes computed with
// plain 64-bit arithmetic, an independent monitor pops and checks them.
module tb_mdu_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mdu_if bus();

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          kind;      // 0 single-cycle, 1 multi-cycle, 2 aborted by reset
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          ncyc;
    } txn_t;

    txn_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_busy = 1'b0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fills a scoreboard entry and advances the architectural HI/LO
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output txn_t t);
        int                ia, ib;
        longint            sa, sb, sp, q, r;
        longint unsigned   ua, ub, up, uq, ur;
        ia = a; ib = b; sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        t.kind = 0; t.ncyc = 0;
        t.old_hi = model_hi; t.old_lo = model_lo;
        case (o)
            3'd1: begin sp = sa * sb; t.kind = 1; t.ncyc = MC;
                        model_hi = sp[63:32]; model_lo = sp[31:0]; end
            3'd2: begin up = ua * ub; t.kind = 1; t.ncyc = MC;
                        model_hi = up[63:32]; model_lo = up[31:0]; end
            3'd3: begin t.kind = 1; t.ncyc = DC;
                        if (b != 32'd0) begin q = sa / sb; r = sa % sb;
                            model_hi = r[31:0]; model_lo = q[31:0]; end end
            3'd4: begin t.kind = 1; t.ncyc = DC;
                        if (b != 32'd0) begin uq = ua / ub; ur = ua % ub;
                            model_hi = ur[31:0]; model_lo = uq[31:0]; end end
            3'd5: model_hi = a;
            3'd6: model_lo = a;
            default: ;
        endcase
        t.exp_hi = model_hi; t.exp_lo = model_lo;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb_q.size() != 0 || mon_busy || bus.busy) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_done: timeout after %0d cycles, expected idle", n);
        end
    endtask

    // Issue one request; optionally inject a stray request in busy cycle 2
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit junk, input logic [2:0] jop, input logic [31:0] ja);
        txn_t t;
        @(negedge clk);
        model_op(o, a, b, t);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        sb_q.push_back(t);
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0; bus.A = $urandom; bus.B = $urandom;
        if (junk && t.kind == 1) begin
            @(negedge clk);
            bus.start = 1'b1; bus.op = jop; bus.A = ja; bus.B = $urandom;
            @(negedge clk);
            bus.start = 1'b0; bus.op = 3'd0;
        end
        wait_done();
    endtask

    // Monitor: pops the oldest expectation once its request has been clocked in
    initial begin
        txn_t t;
        int   cnt;
        forever begin
            @(posedge clk); #1;
            if (sb_q.size() != 0) begin
                t = sb_q.pop_front();
                mon_busy = 1'b1;
                if (t.kind == 0) begin
                    chk("single_busy", {31'd0, bus.busy}, 32'd0);
                    chk("single_hi", bus.HI, t.exp_hi);
                    chk("single_lo", bus.LO, t.exp_lo);
                end else begin
                    cnt = 0;
                    while (bus.busy && cnt < 40) begin
                        chk("hold_hi", bus.HI, t.old_hi);
                        chk("hold_lo", bus.LO, t.old_lo);
                        cnt++;
                        @(posedge clk); #1;
                    end
                    chk("busy_cycles", cnt, t.ncyc);
                    chk("commit_hi", bus.HI, t.exp_hi);
                    chk("commit_lo", bus.LO, t.exp_lo);
                    if (t.kind == 2) begin
                        for (int k = 0; k < DC + 2; k++) begin
                            @(posedge clk); #1;
                            chk("post_abort_busy", {31'd0, bus.busy}, 32'd0);
                            chk("post_abort_hi", bus.HI, 32'd0);
                            chk("post_abort_lo", bus.LO, 32'd0);
                        end
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        txn_t t;
        bus.start = 1'b0; bus.op = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_hi", bus.HI, 32'd0);
        chk("reset_lo", bus.LO, 32'd0);

        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 3'd0, 32'd0);
        chk("t1_hi", bus.HI, 32'hFFFFFFFF);
        chk("t1_lo", bus.LO, 32'hFFFFFFFA);
        issue(3'd2, 32'hFFFFFFFE, 32'd3, 1'b1, 3'd2, 32'd7);
        chk("t2_hi", bus.HI, 32'h00000002);
        chk("t2_lo", bus.LO, 32'hFFFFFFFA);
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 3'd0, 32'd0);
        chk("t3_lo", bus.LO, 32'hFFFFFFFD);
        chk("t3_hi", bus.HI, 32'hFFFFFFFF);
        issue(3'd4, 32'd7, 32'd2, 1'b0, 3'd0, 32'd0);
        chk("t3u_lo", bus.LO, 32'd3);
        chk("t3u_hi", bus.HI, 32'd1);
        issue(3'd5, 32'h00001234, 32'd0, 1'b0, 3'd0, 32'd0);
        issue(3'd1, 32'd1000, 32'd77, 1'b1, 3'd6, 32'h0000DEAD);
        chk("t4_lo", bus.LO, 32'd77000);
        issue(3'd5, 32'h0000AAAA, 32'd0, 1'b0, 3'd0, 32'd0);
        issue(3'd6, 32'h00005555, 32'd0, 1'b0, 3'd0, 32'd0);
        issue(3'd4, 32'd5, 32'd0, 1'b0, 3'd0, 32'd0);
        chk("t5_hi", bus.HI, 32'h0000AAAA);
        chk("t5_lo", bus.LO, 32'h00005555);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 3'd0, 32'd0);
        issue(3'd3, 32'd9, 32'hFFFFFFFC, 1'b0, 3'd0, 32'd0);
        issue(3'd7, 32'd123, 32'd4, 1'b0, 3'd0, 32'd0);

        // DIV aborted by reset in busy cycle 4, stray MULT in busy cycle 2
        @(negedge clk);
        model_op(3'd3, 32'd100, 32'd7, t);
        t.kind = 2; t.ncyc = 4; t.exp_hi = 32'd0; t.exp_lo = 32'd0;
        model_hi = 32'd0; model_lo = 32'd0;
        bus.start = 1'b1; bus.op = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
        sb_q.push_back(t);
        @(negedge clk); bus.start = 1'b0; bus.op = 3'd0;
        @(negedge clk); bus.start = 1'b1; bus.op = 3'd1; bus.A = 32'd3; bus.B = 32'd5;
        @(negedge clk); bus.start = 1'b0; bus.op = 3'd0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_done();

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            int          sel;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0)      b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 9));
            else               b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {{28{a[31]}}, a[3:0]};
            issue(o, a, b, $urandom_range(0, 1) == 1, 3'($urandom_range(1, 6)), $urandom);
        end

        wait_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline. It is fed by the E-stage pipeline register (operation code, forwarded rs/rt values) and produces HI/LO read data that goes into the M-stage pipeline register as the mfhi/mflo result. It models multi-cycle MULT/MULTU/DIV/DIVU latency with a registered busy flag. The hazard unit consumes that busy flag and stalls any D-stage mult/div-class instruction.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal 1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  E-stage instruction is an MDU write op (qualifies op)
op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (NOP)
A  input  32  forwarded rs value from E stage
B  input  32  forwarded rt value from E stage
busy  output  1  registered; high while a mult/div is in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset (rst=1 at posedge): HI=0, LO=0, busy=0, cycle counter=0, and any pending result is discarded. Reset has priority over every other event, including reset in the middle of an operation.
- State: IDLE (busy=0) and RUN (busy=1), plus a 4-bit down-counter and 64-bit shadow {sHI,sLO}.
- IDLE, start=1, op in 1..4 at edge t:
  - Compute the result from A/B at t and capture it into the shadow registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from t+1.
- RUN: the counter decrements on each edge.
  - The edge at which counter==1 writes HI<=sHI and LO<=sLO, sets busy=0, and returns to IDLE.
  - busy is therefore high for exactly N cycles, where N is the configured latency. The new HI/LO are visible in the first cycle after busy falls.
- HI/LO are not modified while busy=1; they hold their previous values until commit.
- Arithmetic:
  - MULT: {sHI,sLO} = signed(A)*signed(B), full 64 bits.
  - MULTU: unsigned 64-bit product.
  - DIV: sLO = signed quotient truncated toward zero; sHI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B==0, DIV/DIVU): the unit still runs DIV_CYCLES busy cycles, but the commit leaves HI/LO unchanged.
- MTHI/MTLO (op 5/6) with start=1 in IDLE: HI<=A or LO<=A at the next edge. busy stays 0, single-cycle.
- start=1 while busy=1, any op: ignored, with no effect on the shadow, counter, HI or LO. The hazard unit guarantees this does not occur in legal flow; the bench still checks that the request is ignored.
- start=0, or op 0/7: no state change.
- MTHI/MTLO and commit cannot coincide, because MTHI/MTLO is ignored while busy=1.
- HI/LO outputs are direct register outputs; mfhi/mflo select between them outside this block.

Test Plan:
1. MULT, A=0xFFFFFFFE, B=3 → busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. HI/LO must hold their old values during busy.
2. MULTU, A=0xFFFFFFFE, B=3 → HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
3. DIV, A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=7, B=2 → LO=3, HI=1.
4. MTHI A=0x00001234 while idle → HI=0x00001234 next edge, busy stays 0. Then issue MULT and, during busy, MTLO A=0xDEAD → LO unaffected; final LO is the product.
5. DIVU A=5, B=0 with HI=0xAAAA, LO=0x5555 beforehand → busy 10 cycles; HI=0xAAAA, LO=0x5555 unchanged.
6. DIV issued, a second MULT with start=1 in busy cycle 2 (ignored), rst=1 in busy cycle 4 → next edge busy=0, HI=0, LO=0. No later commit occurs, and the ignored MULT never executes.
